// File: rtl/down_count_sequencer.sv
// Programmable countdown timer: loads a start value, decrements once every
// PRESCALE clocks down to zero and pulses done for one cycle. It supports
// pause, abort and auto-reload from the captured load value.
module down_count_sequencer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMax = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;

    // Last prescaler phase; with PRESCALE=1 every RUN cycle is a tick.
    assign tick = (presc_q == PMax);

    // Next-state logic; priority at every edge is abort > pause > start/tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        unique case (state_q)
            StIdle: begin
                if (!abort && !pause && start) begin
                    // A zero load is still captured so DONE cannot auto-reload.
                    reload_d = load_val;
                    count_d  = load_val;
                    presc_d  = '0;
                    state_d  = (load_val != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (abort) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = StIdle;
                end else if (pause) begin
                    state_d = StPause;
                end else if (tick) begin
                    presc_d = '0;
                    count_d = count_q - 1'b1;
                    if (count_q == WIDTH'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            StPause: begin
                if (abort) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = StIdle;
                end else if (!pause) begin
                    // Resume at the frozen phase; the resume edge itself is not counted.
                    state_d = StRun;
                end
            end
            StDone: begin
                if (abort) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = StIdle;
                end else if (auto_reload && (reload_q != '0)) begin
                    count_d = reload_q;
                    presc_d = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                count_d = '0;
                presc_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_comb begin
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_down_count_sequencer.sv
// Scoreboard bench for down_count_sequencer: one instance with PRESCALE=1 and
// one with PRESCALE=4. Expected outputs are queued as stimulus is driven and
// compared after the following rising edge.
module tb_down_count_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] start_v, pause_v, abort_v, ar_v, busy_v, done_v;
    logic [3:0] lv_v  [2];
    logic [3:0] cnt_v [2];

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    down_count_sequencer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
        .clk        (clk),
        .rst        (rst),
        .load_val   (lv_v[0]),
        .start      (start_v[0]),
        .pause      (pause_v[0]),
        .abort      (abort_v[0]),
        .auto_reload(ar_v[0]),
        .count      (cnt_v[0]),
        .busy       (busy_v[0]),
        .done       (done_v[0])
    );

    down_count_sequencer #(.WIDTH(4), .PRESCALE(4)) u_p4 (
        .clk        (clk),
        .rst        (rst),
        .load_val   (lv_v[1]),
        .start      (start_v[1]),
        .pause      (pause_v[1]),
        .abort      (abort_v[1]),
        .auto_reload(ar_v[1]),
        .count      (cnt_v[1]),
        .busy       (busy_v[1]),
        .done       (done_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of stimulus into DUT sel and queue its post-edge outputs.
    task automatic cyc(input int sel, input logic st, input logic [3:0] lv, input logic ps,
                       input logic ab, input logic ar, input logic [3:0] ec, input logic eb,
                       input logic ed, input string tag);
        exp_t e;
        @(negedge clk);
        start_v[sel] = st;
        lv_v[sel]    = lv;
        pause_v[sel] = ps;
        abort_v[sel] = ab;
        ar_v[sel]    = ar;
        e.tag  = tag;
        e.sel  = sel;
        e.cnt  = ec;
        e.busy = eb;
        e.done = ed;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input int sel, input logic [3:0] ec, input logic eb, input logic ed,
                             input string tag);
        check_eq({tag, ".count"}, 32'(cnt_v[sel]), 32'(ec));
        check_eq({tag, ".busy"}, 32'(busy_v[sel]), 32'(eb));
        check_eq({tag, ".done"}, 32'(done_v[sel]), 32'(ed));
    endtask

    // Monitor: compare queued expectations just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_now(e.sel, e.cnt, e.busy, e.done, e.tag);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start_v = '0; pause_v = '0; abort_v = '0; ar_v = '0;
        lv_v[0] = '0; lv_v[1] = '0;
        #1;
        check_now(0, 4'd0, 1'b0, 1'b0, "reset_p1");
        check_now(1, 4'd0, 1'b0, 1'b0, "reset_p4");
        @(negedge clk);
        rst = 1'b1;

        // 1: PRESCALE=1, load 3.
        cyc(0, 1, 4'd3, 0, 0, 0, 4'd3, 1, 0, "t1.e0");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "t1.e1");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, "t1.e2");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd0, 1, 1, "t1.e3");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "t1.e4");

        // 2a: PRESCALE=4, load 2.
        cyc(1, 1, 4'd2, 0, 0, 0, 4'd2, 1, 0, "t2a.e0");
        for (int i = 1; i < 4; i++) cyc(1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, $sformatf("t2a.e%0d", i));
        for (int i = 4; i < 8; i++) cyc(1, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, $sformatf("t2a.e%0d", i));
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd0, 1, 1, "t2a.e8");
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "t2a.e9");

        // 2b: pause for 5 edges at prescaler phase 2; decrement 2 edges after release.
        cyc(1, 1, 4'd2, 0, 0, 0, 4'd2, 1, 0, "t2b.e0");
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "t2b.e1");
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "t2b.e2");
        for (int i = 3; i < 8; i++) cyc(1, 0, 4'd0, 1, 0, 0, 4'd2, 1, 0, $sformatf("t2b.e%0d", i));
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "t2b.e8");
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "t2b.e9");
        for (int i = 10; i < 14; i++) cyc(1, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, $sformatf("t2b.e%0d", i));
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd0, 1, 1, "t2b.e14");
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "t2b.e15");

        // 3: auto-reload with load 2, then drop auto_reload.
        cyc(0, 1, 4'd2, 0, 0, 1, 4'd2, 1, 0, "t3.e0");
        for (int r = 0; r < 3; r++) begin
            if (r > 0) cyc(0, 0, 4'd0, 0, 0, 1, 4'd2, 1, 0, $sformatf("t3.r%0d.re", r));
            cyc(0, 0, 4'd0, 0, 0, (r < 2), 4'd1, 1, 0, $sformatf("t3.r%0d.one", r));
            cyc(0, 0, 4'd0, 0, 0, (r < 2), 4'd0, 1, 1, $sformatf("t3.r%0d.done", r));
        end
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "t3.idle");

        // 4: start ignored while busy, abort at count 5.
        cyc(0, 1, 4'd9, 0, 0, 0, 4'd9, 1, 0, "t4.e0");
        cyc(0, 1, 4'd3, 0, 0, 0, 4'd8, 1, 0, "t4.ign");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd7, 1, 0, "t4.e2");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd6, 1, 0, "t4.e3");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd5, 1, 0, "t4.e4");
        cyc(0, 0, 4'd0, 0, 1, 0, 4'd0, 0, 0, "t4.abort");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "t4.after");

        // 5: zero load with auto_reload gives one done, then idle.
        cyc(0, 1, 4'd0, 0, 0, 1, 4'd0, 1, 1, "t5.done");
        cyc(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "t5.idle");
        cyc(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "t5.stay");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "t5.clr");

        // 6: asynchronous reset mid-run at count 6.
        cyc(0, 1, 4'd9, 0, 0, 0, 4'd9, 1, 0, "t6.e0");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd8, 1, 0, "t6.e1");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd7, 1, 0, "t6.e2");
        cyc(0, 0, 4'd0, 0, 0, 0, 4'd6, 1, 0, "t6.e3");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_now(0, 4'd0, 1'b0, 1'b0, "t6.async");
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 1, 4'd1, 0, 0, 0, 4'd1, 1, 0, "t6.p4.e0");
        for (int i = 1; i < 4; i++) cyc(1, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, $sformatf("t6.p4.e%0d", i));
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd0, 1, 1, "t6.p4.done");
        cyc(1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "t6.p4.idle");

        @(negedge clk);
        @(negedge clk);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
